// File: rtl/ksa_controller.sv
// RC4 key-scheduling sequencer. It first fills the S-memory with the identity
// permutation, then runs the 256 j/swap iterations over the single port.
module ksa_controller #(
  parameter int KEY_W  = 24,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [KEY_W-1:0]  secret_key,
  input  logic [ADDR_W-1:0] q,
  output logic [ADDR_W-1:0] address,
  output logic [ADDR_W-1:0] data,
  output logic              wren,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE, INIT, RD_SI, CAP_SI, RD_SJ, CAP_SJ, WR_SI, WR_SJ, DONE
  } state_t;

  state_t            state, state_nx;
  logic [KEY_W-1:0]  key_r;
  logic [ADDR_W-1:0] i, j, si, j_nx;
  logic [1:0]        kidx;
  logic [7:0]        key_byte;
  logic              i_last;

  assign i_last = (i == {ADDR_W{1'b1}});

  // kidx tracks i mod 3 so no divider is needed
  always_comb begin
    case (kidx)
      2'd0:    key_byte = key_r[KEY_W-1 -: 8];
      2'd1:    key_byte = key_r[KEY_W-9 -: 8];
      default: key_byte = key_r[7:0];
    endcase
  end

  assign j_nx = j + q + ADDR_W'(key_byte);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = INIT;
      INIT:    if (i_last) state_nx = RD_SI;
      RD_SI:   state_nx = CAP_SI;
      CAP_SI:  state_nx = RD_SJ;
      RD_SJ:   state_nx = CAP_SJ;
      CAP_SJ:  state_nx = WR_SI;
      WR_SI:   state_nx = WR_SJ;
      WR_SJ:   state_nx = i_last ? DONE : RD_SI;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are loaded on the edge entering the state they belong to, so
  // each state's address/data/wren are stable for its whole cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      address <= '0;
      data    <= '0;
      wren    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      i       <= '0;
      j       <= '0;
      si      <= '0;
      kidx    <= '0;
      key_r   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          key_r   <= secret_key;
          i       <= '0;
          j       <= '0;
          kidx    <= '0;
          done    <= 1'b0;
          busy    <= 1'b1;
          address <= '0;
          data    <= '0;
          wren    <= 1'b1;
        end
        INIT: begin
          if (i_last) begin
            i       <= '0;
            address <= '0;
            wren    <= 1'b0;
          end else begin
            i       <= i + ADDR_W'(1);
            address <= i + ADDR_W'(1);
            data    <= i + ADDR_W'(1);
          end
        end
        CAP_SI: begin
          si      <= q;
          j       <= j_nx;
          address <= j_nx;
        end
        // data doubles as the sj holding register
        CAP_SJ: begin
          address <= i;
          data    <= q;
          wren    <= 1'b1;
        end
        WR_SI: begin
          address <= j;
          data    <= si;
          wren    <= 1'b1;
        end
        WR_SJ: begin
          wren <= 1'b0;
          if (i_last) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            i       <= i + ADDR_W'(1);
            address <= i + ADDR_W'(1);
            kidx    <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_controller.sv
// Directed bench for ksa_controller: behavioural S-memory, RC4 KSA reference
// model, and a write log used to check the init and first swap sequences.
module tb_ksa_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  q;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wren;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  mem   [256];
  logic [7:0]  exp_s [256];
  logic [15:0] wlog  [$];
  int          busy_cnt = 0;
  int          bad_addr = 0;

  always #5 clk = ~clk;

  ksa_controller #(.KEY_W(24), .ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .secret_key(secret_key),
    .q(q), .address(address), .data(data), .wren(wren), .busy(busy), .done(done)
  );

  // single-port memory: registered address, q valid the following cycle
  always @(posedge clk) begin
    if (wren) mem[address] <= data;
    q <= mem[address];
  end

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (wren) begin
      wlog.push_back({address, data});
      if ($isunknown(address)) bad_addr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model(input logic [23:0] key);
    logic [7:0] jj, t, kb;
    for (int k = 0; k < 256; k++) exp_s[k] = 8'(k);
    jj = 8'd0;
    for (int k = 0; k < 256; k++) begin
      case (k % 3)
        0:       kb = key[23:16];
        1:       kb = key[15:8];
        default: kb = key[7:0];
      endcase
      jj = jj + exp_s[k] + kb;
      t = exp_s[k]; exp_s[k] = exp_s[jj]; exp_s[jj] = t;
    end
  endtask

  task automatic pulse_start(input logic [23:0] key);
    @(negedge clk);
    start = 1'b1;
    secret_key = key;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic cmp_mem(input string tag);
    int errs;
    errs = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) errs++;
    chk(tag, errs, 0);
  endtask

  initial begin
    int base, b0, errs;
    reset_n = 1'b0;
    start = 1'b0;
    secret_key = 24'h0;
    repeat (3) @(negedge clk);
    chk("rst_address", address, 8'h00);
    chk("rst_data", data, 8'h00);
    chk("rst_wren", wren, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset_n = 1'b1;

    // reset in the middle of the init fill
    pulse_start(24'h000000);
    for (int n = 0; n < 300 && !(wren && address == 8'd100); n++) @(negedge clk);
    chk("midinit_reached", address, 8'd100);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_address", address, 8'h00);
    chk("midrst_data", data, 8'h00);
    chk("midrst_wren", wren, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_stays", {busy, wren}, 2'b00);

    // init pattern and the first self-swaps with an all-zero key
    base = wlog.size();
    b0 = busy_cnt;
    pulse_start(24'h000000);
    wait_done("k0");
    errs = 0;
    for (int k = 0; k < 256; k++) if (wlog[base+k] !== {8'(k), 8'(k)}) errs++;
    chk("init_pattern", errs, 0);
    chk("init_w100", wlog[base+100], 16'h6464);
    chk("swap0_a", wlog[base+256], 16'h0000);
    chk("swap0_b", wlog[base+257], 16'h0000);
    chk("swap1_a", wlog[base+258], 16'h0101);
    chk("swap1_b", wlog[base+259], 16'h0101);
    chk("swap2_a", wlog[base+260], 16'h0203);
    chk("swap2_b", wlog[base+261], 16'h0302);
    chk("k0_writes", wlog.size() - base, 256 + 512);
    chk("k0_busy_cycles", busy_cnt - b0, 1792);
    model(24'h000000);
    cmp_mem("k0_final_s");

    // full KSA with a non-trivial key; done must hold after completion
    b0 = busy_cnt;
    pulse_start(24'h000249);
    chk("start_clears_done", done, 1'b0);
    wait_done("k249");
    chk("k249_busy_cycles", busy_cnt - b0, 1792);
    model(24'h000249);
    cmp_mem("k249_final_s");
    repeat (5) @(negedge clk);
    chk("done_held", {done, busy}, 2'b10);

    // start and key change mid-run are ignored
    b0 = busy_cnt;
    pulse_start(24'h123456);
    repeat (500) @(negedge clk);
    start = 1'b1;
    secret_key = 24'hABCDEF;
    @(negedge clk);
    start = 1'b0;
    chk("midrun_busy", busy, 1'b1);
    wait_done("k123456");
    chk("proto_busy_cycles", busy_cnt - b0, 1792);
    model(24'h123456);
    cmp_mem("proto_final_s");

    // wrap-heavy key, started right after done
    b0 = busy_cnt;
    pulse_start(24'hFFFFFF);
    chk("restart_done_low", done, 1'b0);
    chk("restart_busy", busy, 1'b1);
    wait_done("kff");
    chk("kff_busy_cycles", busy_cnt - b0, 1792);
    model(24'hFFFFFF);
    cmp_mem("kff_final_s");
    chk("wr_addr_known", bad_addr, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
